// File: rtl/mem_pkg.sv
// mem_pkg: shared load/store op codes, store-engine state encoding and byte-count helper.
package mem_pkg;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // BYTE0..BYTE3 sit on adjacent bits so a left shift advances to the next byte
    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_BYTE0 = 6'b000010,
        S_BYTE1 = 6'b000100,
        S_BYTE2 = 6'b001000,
        S_BYTE3 = 6'b010000,
        S_DONE  = 6'b100000
    } state_t;

    // zero marks an illegal store op
    function automatic logic [2:0] byte_count(logic [2:0] op);
        return op == SB ? 3'd1 : op == SH ? 3'd2 : op == SW ? 3'd4 : 3'd0;
    endfunction
endpackage

// File: rtl/store_writer.sv
// store_writer: byte-serial little-endian store engine driving a byte-wide data RAM.
module store_writer
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_en,
    input  logic              we,
    input  logic [2:0]        mem_op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_w_en,
    output logic              ram_w_ready,
    output logic              ram_w_err,
    output logic              busy
);
    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [31:0]       data;
    logic [2:0]        cnt;
    logic              err;
    logic [1:0]        k;
    logic [1:0]        kn;
    logic              last;
    logic [2:0]        req_cnt;
    logic              unused_addr;

    assign unused_addr = ^addr[31:ADDR_W];
    assign req_cnt = byte_count(mem_op);

    always_comb begin
        k = state == S_BYTE1 ? 2'd1 : state == S_BYTE2 ? 2'd2 : state == S_BYTE3 ? 2'd3 : 2'd0;
        kn = k + 2'd1;
        last = ({1'b0, k} + 3'd1) == cnt;
    end

    // outputs are computed for the state being entered, so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            base <= '0;
            data <= '0;
            cnt <= '0;
            err <= 1'b0;
            ram_addr <= '0;
            ram_wdata <= '0;
            ram_w_en <= 1'b0;
            ram_w_ready <= 1'b0;
            ram_w_err <= 1'b0;
            busy <= 1'b0;
        end else begin
            ram_addr <= '0;
            ram_wdata <= '0;
            ram_w_en <= 1'b0;
            ram_w_ready <= 1'b0;
            ram_w_err <= 1'b0;
            case (state)
                S_IDLE: if (we && ram_en) begin
                    base <= addr[ADDR_W-1:0];
                    data <= wdata;
                    cnt <= req_cnt;
                    err <= req_cnt == 3'd0;
                    busy <= 1'b1;
                    if (req_cnt == 3'd0) begin
                        state <= S_DONE;
                        ram_w_ready <= 1'b1;
                        ram_w_err <= 1'b1;
                    end else begin
                        state <= S_BYTE0;
                        ram_w_en <= 1'b1;
                        ram_addr <= addr[ADDR_W-1:0];
                        ram_wdata <= wdata[7:0];
                    end
                end
                S_BYTE0, S_BYTE1, S_BYTE2, S_BYTE3: if (last) begin
                    state <= S_DONE;
                    ram_w_ready <= 1'b1;
                    ram_w_err <= err;
                end else begin
                    state <= state_t'(state << 1);
                    ram_w_en <= 1'b1;
                    ram_addr <= base + ADDR_W'(kn);
                    ram_wdata <= data[{kn, 3'b000} +: 8];
                end
                default: begin
                    state <= S_IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_store_writer.sv
// tb_store_writer: directed stimulus with a cycle-indexed expectation model and literal pins.
module tb_store_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_en = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  mem_op = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_w_en;
    logic        ram_w_ready;
    logic        ram_w_err;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    store_writer #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .ram_en(ram_en), .we(we), .mem_op(mem_op),
        .addr(addr), .wdata(wdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_w_en(ram_w_en), .ram_w_ready(ram_w_ready), .ram_w_err(ram_w_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // expectation model: per-cycle output tables filled when a request is accepted
    localparam int N = 1024;
    bit        e_wen[N];
    bit        e_rdy[N];
    bit        e_err[N];
    bit        e_busy[N];
    bit [15:0] e_addr[N];
    bit [7:0]  e_data[N];
    int        cyc = 0;
    int        free_at = 0;
    int        n_model;
    bit        run = 1'b0;

    function automatic int nbytes(input logic [2:0] op);
        return op == 3'b000 ? 1 : op == 3'b001 ? 2 : op == 3'b010 ? 4 : 0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                e_wen[cyc+i] = 0;
                e_rdy[cyc+i] = 0;
                e_err[cyc+i] = 0;
                e_busy[cyc+i] = 0;
            end
            free_at = cyc;
        end else if (cyc >= free_at && we && ram_en) begin
            n_model = nbytes(mem_op);
            for (int i = 0; i < n_model; i++) begin
                e_wen[cyc+i] = 1;
                e_busy[cyc+i] = 1;
                e_addr[cyc+i] = 16'(addr[15:0] + i);
                e_data[cyc+i] = wdata[8*i +: 8];
            end
            e_rdy[cyc+n_model] = 1;
            e_err[cyc+n_model] = n_model == 0;
            e_busy[cyc+n_model] = 1;
            free_at = cyc + n_model + 2;
        end
    end

    always @(negedge clk) begin
        if (run && !rst) begin
            check("m_w_en", ram_w_en, e_wen[cyc]);
            check("m_ready", ram_w_ready, e_rdy[cyc]);
            check("m_err", ram_w_err, e_err[cyc]);
            check("m_busy", busy, e_busy[cyc]);
            if (e_wen[cyc]) begin
                check("m_addr", ram_addr, e_addr[cyc]);
                check("m_data", ram_wdata, e_data[cyc]);
            end
        end
    end

    task automatic txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                       input int tweak, output int nw, output logic [31:0] bytes,
                       output logic [15:0] fa, output logic [15:0] la, output int rc,
                       output logic es);
        @(posedge clk);
        #2;
        we = 1'b1;
        ram_en = 1'b1;
        mem_op = op;
        addr = a;
        wdata = d;
        nw = 0;
        bytes = '0;
        fa = '0;
        la = '0;
        rc = -1;
        es = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 8 && rc < 0; k++) begin
            @(negedge clk);
            if (ram_w_en) begin
                if (nw == 0) fa = ram_addr;
                la = ram_addr;
                bytes = {ram_wdata, bytes[31:8]};
                nw++;
            end
            if (ram_w_ready) begin
                rc = k;
                es = ram_w_err;
                we = 1'b0;
            end
            if (k == tweak) begin
                we = 1'b0;
                ram_en = 1'b0;
                wdata = '0;
                mem_op = 3'b000;
                addr = '0;
            end
        end
        if (rc < 0) begin
            check("ready_timeout", 32'd0, 32'd1);
            we = 1'b0;
        end
    endtask

    int          nw;
    int          rc;
    int          nr;
    logic [31:0] bytes;
    logic [15:0] fa;
    logic [15:0] la;
    logic        es;

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        run = 1'b1;
        @(negedge clk);
        check("rst_w_en", ram_w_en, 0);
        check("rst_ready", ram_w_ready, 0);
        check("rst_err", ram_w_err, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_wdata", ram_wdata, 0);

        txn(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, nw, bytes, fa, la, rc, es);
        check("sw_nw", nw, 4);
        check("sw_bytes", bytes, 32'hDEAD_BEEF);
        check("sw_first", fa, 16'h0100);
        check("sw_last", la, 16'h0103);
        check("sw_ready_cyc", rc, 5);
        check("sw_err", es, 0);

        txn(3'b000, 32'h0000_0007, 32'h1234_5678, 0, nw, bytes, fa, la, rc, es);
        check("sb_nw", nw, 1);
        check("sb_byte", bytes[31:24], 8'h78);
        check("sb_addr", fa, 16'h0007);
        check("sb_ready_cyc", rc, 2);
        check("sb_err", es, 0);

        txn(3'b001, 32'h0000_FFFF, 32'h0000_A55A, 0, nw, bytes, fa, la, rc, es);
        check("sh_nw", nw, 2);
        check("sh_bytes", bytes[31:16], 16'hA55A);
        check("sh_first", fa, 16'hFFFF);
        check("sh_wrap", la, 16'h0000);
        check("sh_ready_cyc", rc, 3);

        txn(3'b111, 32'h0000_0040, 32'h0BAD_0BAD, 0, nw, bytes, fa, la, rc, es);
        check("ill_nw", nw, 0);
        check("ill_ready_cyc", rc, 1);
        check("ill_err", es, 1);

        txn(3'b010, 32'h0000_0300, 32'hCAFE_F00D, 2, nw, bytes, fa, la, rc, es);
        check("hold_nw", nw, 4);
        check("hold_bytes", bytes, 32'hCAFE_F00D);
        check("hold_first", fa, 16'h0300);
        check("hold_last", la, 16'h0303);
        check("hold_ready_cyc", rc, 5);

        @(posedge clk);
        #2;
        we = 1'b1;
        ram_en = 1'b1;
        mem_op = 3'b010;
        addr = 32'h0000_0200;
        wdata = 32'h1122_3344;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("pre_rst_w_en", ram_w_en, 1);
        check("pre_rst_addr", ram_addr, 16'h0202);
        check("pre_rst_data", ram_wdata, 8'h22);
        #1 rst = 1'b1;
        we = 1'b0;
        #1;
        check("mid_rst_w_en", ram_w_en, 0);
        check("mid_rst_addr", ram_addr, 0);
        check("mid_rst_data", ram_wdata, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", ram_w_ready, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        nw = 0;
        repeat (6) begin
            @(negedge clk);
            if (ram_w_en) nw++;
        end
        check("post_rst_writes", nw, 0);

        @(posedge clk);
        #2;
        we = 1'b1;
        ram_en = 1'b1;
        mem_op = 3'b000;
        addr = 32'h0000_0030;
        wdata = 32'h0000_00AB;
        nw = 0;
        nr = 0;
        repeat (13) begin
            @(negedge clk);
            if (ram_w_en) nw++;
            if (ram_w_ready) nr++;
        end
        we = 1'b0;
        check("sb_stream_writes", nw, 4);
        check("sb_stream_readies", nr, 4);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
